// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and MIPS funct encodings for the multiply/divide unit.
package mdu_pkg;
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_t;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} mdu_state_t;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  // The low two funct bits of the MDU group line up with the op encoding.
  function automatic mdu_op_t funct_to_op(input logic [5:0] f);
    return mdu_op_t'(f[1:0]);
  endfunction
endpackage

// File: rtl/mdu_iter_step.sv
// mdu_iter_step: one shift-add multiply step or one restoring-divide step.
module mdu_iter_step #(
  parameter int N = 32
) (
  input  logic         div,
  input  logic [N-1:0] acc,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] opnd,
  output logic [N-1:0] acc_n,
  output logic [N-1:0] lo_n,
  output logic         qbit
);
  logic [N:0]   sum;
  logic [N:0]   sh;
  logic [N+1:0] diff;
  always_comb begin
    sum   = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    sh    = {acc, lo[N-1]};
    diff  = {1'b0, sh} - {2'b00, opnd};
    // Trial subtraction succeeds when it is non-negative and fits the remainder.
    qbit  = div & (diff[N+1:N] == 2'b00);
    acc_n = div ? (qbit ? diff[N-1:0] : sh[N-1:0]) : sum[N:1];
    lo_n  = {sum[0], lo[N-1:1]};
  end
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         hilo_rd,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [N-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic         stall,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);
  mdu_state_t     state, state_n;
  mdu_op_t        op_in;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   acc, lo_w, opnd, acc_n, lo_n, a_abs, b_abs, q_f, r_f, res_hi, res_lo;
  logic [2*N-1:0] prod_f;
  logic           is_div, div_in, neg_q, neg_r, div0, qbit, sgn, accept;

  mdu_iter_step #(.N(N)) u_step (
    .div  (is_div),
    .acc  (acc),
    .lo   (lo_w),
    .opnd (opnd),
    .acc_n(acc_n),
    .lo_n (lo_n),
    .qbit (qbit)
  );

  always_comb begin
    busy    = (state == S_CALC) | (state == S_FIX);
    done    = state == S_DONE;
    stall   = busy & (hilo_rd | start);
    accept  = start & ((state == S_IDLE) | (state == S_DONE));
    state_n = (state == S_CALC) ? ((cnt == '0) ? S_FIX : S_CALC) :
              (state == S_FIX)  ? S_DONE :
              accept            ? S_CALC : S_IDLE;
  end

  always_comb begin
    op_in  = mdu_op_t'(op);
    sgn    = (op_in == OP_MULT) | (op_in == OP_DIV);
    div_in = (op_in == OP_DIV) | (op_in == OP_DIVU);
    a_abs  = (sgn & a[N-1]) ? -a : a;
    b_abs  = (sgn & b[N-1]) ? -b : b;
    prod_f = neg_q ? -{acc, lo_w} : {acc, lo_w};
    q_f    = div0 ? '1 : (neg_q ? -lo_w : lo_w);
    r_f    = neg_r ? -acc : acc;
    res_hi = is_div ? r_f : prod_f[2*N-1:N];
    res_lo = is_div ? q_f : prod_f[N-1:0];
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else        state <= state_n;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt    <= '0;
      acc    <= '0;
      lo_w   <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (accept) begin
        is_div <= div_in;
        neg_q  <= sgn & (a[N-1] ^ b[N-1]);
        neg_r  <= sgn & a[N-1];
        div0   <= b == '0;
        cnt    <= CW'(N-1);
        acc    <= '0;
        lo_w   <= div_in ? a_abs : b_abs;
        opnd   <= div_in ? b_abs : a_abs;
      end else if (state == S_CALC) begin
        acc  <= acc_n;
        lo_w <= is_div ? {lo_w[N-2:0], qbit} : lo_n;
        cnt  <= cnt - 1'b1;
      end
      // Results land only on the FIX edge; MTHI/MTLO are dropped while busy.
      if (state == S_FIX) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (!busy) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: scoreboard bench for the multiply/divide sequencer.
module tb_mdu_sequencer;
  localparam int N = 32;
  logic         clk = 1'b0, reset = 1'b0, start = 1'b0, hilo_rd = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [N-1:0] a = '0, b = '0, wdata = '0;
  logic         busy, done, stall;
  logic [N-1:0] hi, lo;
  int           errs = 0, checks = 0;
  logic [63:0]  sb[$];

  always #5 clk = ~clk;

  mdu_sequencer #(.N(N), .CW(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hilo_rd(hilo_rd), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      2'd0:    return 64'(sx * sy);
      2'd1:    return 64'(x) * 64'(y);
      2'd2:    return (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(sx % sy), 32'(sx / sy)};
      default: return (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
    endcase
  endfunction

  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    int k;
    logic [63:0] e;
    sb.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
    chk("busy_e0", busy, 1);
    wait_done(k);
    chk("latency", k, N + 1);
    e = sb.pop_front();
    chk("hi", hi, e[63:32]);
    chk("lo", lo, e[31:0]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic [N-1:0] ph, pl, x, y;
    logic [1:0] o;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(negedge clk) reset = 1'b1;

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    run_op(2'd3, 32'd100, 32'd0);
    chk("divu0_hi", hi, 32'h0000_0064);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf_hi", hi, 32'h0);
    chk("ovf_lo", lo, 32'h8000_0000);

    // MTLO in the DONE cycle overrides the fresh result
    @(negedge clk); lo_we = 1'b1; wdata = 32'h5555_AAAA;
    @(posedge clk); #1; lo_we = 1'b0;
    chk("mtlo_done", lo, 32'h5555_AAAA);
    chk("mthi_keep", hi, 32'h0);
    @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_0001;
    @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
    chk("mthilo_hi", hi, 32'hCAFE_0001);
    chk("mthilo_lo", lo, 32'hCAFE_0001);

    for (int i = 0; i < 12; i++) begin
      o = 2'($urandom_range(0, 3));
      x = (i % 5 == 1) ? 32'h8000_0000 : $urandom;
      y = (i % 4 == 0) ? 32'h0 : (i % 4 == 1) ? 32'($urandom_range(1, 9)) : $urandom;
      run_op(o, x, y);
    end

    // Hazards: MFHI, second start and MTHI held while busy
    @(negedge clk);
    ph = hi; pl = lo;
    sb.push_back(model(2'd1, 32'd5, 32'd6));
    start = 1'b1; op = 2'd1; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    op = 2'd0; a = 32'd9; b = 32'd9;
    hilo_rd = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    k = 0;
    while (!done && k < 60) begin
      chk("haz_stall", stall, 1);
      chk("haz_hold_hi", hi, ph);
      chk("haz_hold_lo", lo, pl);
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0; hilo_rd = 1'b0; hi_we = 1'b0;
    chk("haz_latency", k, N + 1);
    chk("haz_stall_done", stall, 0);
    begin
      logic [63:0] e;
      e = sb.pop_front();
      chk("haz_hi", hi, e[63:32]);
      chk("haz_lo", lo, e[31:0]);
    end
    @(posedge clk); #1;
    chk("haz_idle", busy, 0);
    chk("haz_nodone", done, 0);

    // Asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'd123; b = 32'd456;
    @(posedge clk); #1;
    start = 1'b0; hilo_rd = 1'b1;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_stall", stall, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    @(negedge clk); reset = 1'b1; hilo_rd = 1'b0;
    @(posedge clk); #1;
    chk("arst_idle", busy, 0);
    @(negedge clk); lo_we = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1; lo_we = 1'b0;
    chk("mtlo_lo", lo, 32'h0000_1234);
    chk("mtlo_hi", hi, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
